// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory: one word-addressed request, one response word.
interface instr_fetch_stage_if;
  logic [31:0] IM_ADDR;
  logic        IM_REQ;
  logic        IM_RDY;
  logic        IM_RVALID;
  logic [31:0] IM_RDATA;

  modport master (
    output IM_ADDR,
    output IM_REQ,
    input  IM_RDY,
    input  IM_RVALID,
    input  IM_RDATA
  );

  modport slave (
    input  IM_ADDR,
    input  IM_REQ,
    output IM_RDY,
    output IM_RVALID,
    output IM_RDATA
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch in flight,
// buffers returned words in a small FIFO and feeds the decoder one IR per cycle.
module instr_fetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  instr_fetch_stage_if.master        im,
  input  logic                       BR_TAKEN,
  input  logic [31:0]                BR_TARGET,
  input  logic                       STALL,
  output logic [31:0]                IR,
  output logic [31:0]                PC_1,
  output logic                       IR_VALID
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg;
  logic [31:0]   out_addr_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;

  logic [31:0]   buf_ir  [DEPTH];
  logic [31:0]   buf_pc1 [DEPTH];

  logic          req;
  logic          issue;
  logic          push;
  logic          pop;

  // A slot is reserved at issue time, so a kept response can always be pushed.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    req        = (state_reg == S_IDLE) && (count_reg < FULL) && !BR_TAKEN && !RESET;
    issue      = req && im.IM_RDY;
    pop        = !BR_TAKEN && !STALL && (count_reg != '0);
    case (state_reg)
      S_IDLE: begin
        if (issue) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (im.IM_RVALID) begin
          push       = !BR_TAKEN;
          state_next = S_IDLE;
        end else if (BR_TAKEN) begin
          state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (im.IM_RVALID) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign im.IM_REQ  = req;
  assign im.IM_ADDR = pc_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      out_addr_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      IR           <= '0;
      PC_1         <= '0;
      IR_VALID     <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (BR_TAKEN)   pc_reg <= BR_TARGET;
      else if (issue) pc_reg <= pc_reg + 32'd1;

      if (issue) out_addr_reg <= pc_reg;

      // Redirect flushes the buffer and wins over any push/pop this cycle.
      if (BR_TAKEN) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        IR         <= '0;
        IR_VALID   <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + CW'(push) - CW'(pop);
        if (!STALL) begin
          if (pop) begin
            IR       <= buf_ir[rd_ptr_reg];
            PC_1     <= buf_pc1[rd_ptr_reg];
            IR_VALID <= 1'b1;
          end else begin
            IR       <= '0;
            IR_VALID <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      buf_ir[wr_ptr_reg]  <= im.IM_RDATA;
      buf_pc1[wr_ptr_reg] <= out_addr_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios then random stall/redirect/ready
// traffic, checked every cycle against a transaction-level queue model.
module tb_instr_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] BR_TARGET = '0;
  logic [31:0] IR;
  logic [31:0] PC_1;
  logic        IR_VALID;

  instr_fetch_stage_if im();

  instr_fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .im       (im),
    .BR_TAKEN (BR_TAKEN),
    .BR_TARGET(BR_TARGET),
    .STALL    (STALL),
    .IR       (IR),
    .PC_1     (PC_1),
    .IR_VALID (IR_VALID)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: PC, one outstanding-fetch flag with keep/drop, a FIFO queue.
  logic [31:0] m_pc, m_out_addr, m_ir, m_pc1;
  logic        m_irv, m_busy, m_keep;
  logic [63:0] m_q [$];

  // Memory responder.
  logic        mem_pend = 1'b0;
  int          mem_due = 0;
  logic [31:0] mem_addr = '0;
  int          mem_k = 1;
  logic        force_stale = 1'b0;
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h10;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_out_addr = '0;
    m_ir       = '0;
    m_pc1      = '0;
    m_irv      = 1'b0;
    m_busy     = 1'b0;
    m_keep     = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                            input logic iss, input logic rv, input logic [31:0] rdata);
    logic [63:0] e;
    if (br) begin
      m_q.delete();
      m_ir  = '0;
      m_irv = 1'b0;
    end else if (!st) begin
      if (m_q.size() > 0) begin
        e     = m_q.pop_front();
        m_ir  = e[63:32];
        m_pc1 = e[31:0];
        m_irv = 1'b1;
        $display("ir load: pc=%h ir=%h", e[31:0] - 32'd1, e[63:32]);
      end else begin
        m_ir  = '0;
        m_irv = 1'b0;
      end
    end
    if (m_busy && rv) begin
      if (m_keep && !br) m_q.push_back({rdata, m_out_addr + 32'd1});
      m_busy = 1'b0;
    end else if (m_busy && br) begin
      m_keep = 1'b0;
    end
    if (br) m_pc = tgt;
    else if (iss) begin
      m_busy     = 1'b1;
      m_keep     = 1'b1;
      m_out_addr = m_pc;
      m_pc       = m_pc + 32'd1;
    end
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at negedge.
  task automatic run_cycle(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
    logic        rv, acc, exp_req;
    logic [31:0] rdata;
    STALL     = st;
    BR_TAKEN  = br;
    BR_TARGET = tgt;
    im.IM_RDY = rdy;
    rv        = (mem_pend && (cyc == mem_due)) || force_stale;
    rdata     = force_stale ? 32'hBAD0_0BAD : mem_word(mem_addr);
    im.IM_RVALID = rv;
    im.IM_RDATA  = rdata;
    @(negedge CLK);
    if (RESET) model_reset();
    exp_req = !RESET && !m_busy && (m_q.size() < DEPTH) && !br;
    check_value("im_req",   {31'b0, im.IM_REQ}, {31'b0, exp_req});
    check_value("im_addr",  im.IM_ADDR, m_pc);
    check_value("ir",       IR, m_ir);
    check_value("pc_1",     PC_1, m_pc1);
    check_value("ir_valid", {31'b0, IR_VALID}, {31'b0, m_irv});
    acc = im.IM_REQ && rdy;
    if (rv) mem_pend = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_due  = cyc + mem_k;
      mem_addr = im.IM_ADDR;
    end
    if (!RESET) model_step(st, br, tgt, rdy && exp_req, rv, rdata);
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && m_busy; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    im.IM_RDY    = 1'b0;
    im.IM_RVALID = 1'b0;
    im.IM_RDATA  = '0;
    model_reset();

    repeat (2) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    RESET = 1'b0;

    // Streaming with k=1: one instruction every two cycles.
    mem_k = 1;
    repeat (8) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall fills the buffer, then drains on consecutive cycles.
    repeat (5) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while waiting; late response is discarded.
    drain();
    mem_k = 3;
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b0, 1'b1, 32'h40, 1'b1);
    mem_k = 1;
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect coincident with response under stall.
    drain();
    mem_k = 1;
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h80, 1'b1);
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Memory not ready: request held, PC stable.
    drain();
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-fetch, stale response after release.
    drain();
    mem_k = 3;
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    RESET    = 1'b1;
    mem_pend = 1'b0;
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    RESET = 1'b0;
    force_stale = 1'b1;
    run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    force_stale = 1'b0;
    mem_k = 1;
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    repeat (400) begin
      mem_k = $urandom_range(1, 3);
      run_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8,
                $urandom, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
